// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file: NUM_REGS byte-writable 32-bit registers exported to fabric logic.
// Define AXIL_REG_SLAVE_ADDR_ERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_REGS           = 4,
  parameter logic [31:0] RESET_VALUE        = 32'h0
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]           reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NB    = DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t         w_state_reg;
  r_state_t         r_state_reg;
  logic             awready_reg, wready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [1:0]       bresp_reg, rresp_reg;
  logic [DW-1:0]    rdata_reg;
  logic [IDX_W-1:0] awidx_reg;
  logic [DW-1:0]    wdata_reg;
  logic [NB-1:0]    wstrb_reg;

  logic [DW-1:0]    regs_q [NUM_REGS];
  logic             aw_hs, w_hs, ar_hs, wr_fire, wr_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DW-1:0]    wr_data, rd_word;
  logic [NB-1:0]    wr_strb;
  logic [1:0]       wr_resp, rd_resp;
  logic             unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs  = S_AXI_AWVALID && awready_reg;
  assign w_hs   = S_AXI_WVALID && wready_reg;
  assign ar_hs  = S_AXI_ARVALID && arready_reg;
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Each half of a write comes either from its latch or straight off the bus.
  always_comb begin
    wr_idx      = (w_state_reg == W_HAVE_ADDR) ? awidx_reg : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    wr_data     = (w_state_reg == W_HAVE_DATA) ? wdata_reg : S_AXI_WDATA;
    wr_strb     = (w_state_reg == W_HAVE_DATA) ? wstrb_reg : S_AXI_WSTRB;
    wr_in_range = int'(wr_idx) < NUM_REGS;
    case (w_state_reg)
      W_IDLE:      wr_fire = aw_hs && w_hs;
      W_HAVE_ADDR: wr_fire = w_hs;
      W_HAVE_DATA: wr_fire = aw_hs;
      default:     wr_fire = 1'b0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(rd_idx) == k) rd_word = regs_q[k];
    end
  end

`ifdef AXIL_REG_SLAVE_ADDR_ERR_EN
  assign wr_resp = wr_in_range ? 2'b00 : 2'b10;
  assign rd_resp = (int'(rd_idx) < NUM_REGS) ? 2'b00 : 2'b10;
`else
  assign wr_resp = 2'b00;
  assign rd_resp = 2'b00;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic          hit;
      logic [DW-1:0] value_reg;
      logic          pulse_reg;

      assign hit = wr_fire && wr_in_range && (int'(wr_idx) == gi);

      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          value_reg <= RESET_VALUE;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          for (int b = 0; b < NB; b++) begin
            if (hit && wr_strb[b]) value_reg[8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end

      assign regs_q[gi]            = value_reg;
      assign reg_out[32*gi +: 32]  = value_reg;
      assign reg_wr_pulse[gi]      = pulse_reg;
    end
  endgenerate

  // Readies stay low during reset and rise on the first edge after release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      awidx_reg   <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_resp;
            w_state_reg <= W_RESP;
          end else if (aw_hs) begin
            awidx_reg   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_HAVE_ADDR;
          end else if (w_hs) begin
            wdata_reg   <= S_AXI_WDATA;
            wstrb_reg   <= S_AXI_WSTRB;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b0;
            w_state_reg <= W_HAVE_DATA;
          end else begin
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        W_HAVE_ADDR, W_HAVE_DATA: begin
          if (wr_fire) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_resp;
            w_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= 2'b00;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_reg   <= rd_word;
            rresp_reg   <= rd_resp;
            rvalid_reg  <= 1'b1;
            arready_reg <= 1'b0;
            r_state_reg <= R_RESP;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave (NUM_REGS=3): directed vector table, hand-written corner sequences,
// and randomized transactions checked against an array model of the register file.
module tb_axil_reg_slave;

  localparam int NR = 3;
`ifdef AXIL_REG_SLAVE_ADDR_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0] reg_wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl [NR];

  axil_reg_slave #(.NUM_REGS(NR)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] mdl_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[32*k +: 32] = mdl[k];
    return f;
  endfunction

  // Reference behaviour: byte-masked merge into the addressed word; out-of-range writes vanish.
  task automatic mdl_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
    int idx = int'(addr) / 4;
    logic [31:0] mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    pulse = '0;
    if (idx < NR) begin
      mdl[idx] = (mdl[idx] & ~mask) | (data & mask);
      pulse[idx] = 1'b1;
      resp = 2'b00;
    end else begin
      resp = OOR_RESP;
    end
  endtask

  task automatic mdl_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int idx = int'(addr) / 4;
    data = (idx < NR) ? mdl[idx] : 32'h0;
    resp = (idx < NR) ? 2'b00 : OOR_RESP;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_pulse}, '0);
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_regs"}, reg_out, '0);
  endtask

  // lead > 0: WVALID leads AWVALID by lead cycles; lead < 0: AWVALID leads WVALID.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int b_hold,
                           input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
    awvalid = (lead <= 0);
    wvalid  = (lead >= 0);
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0;  end
      if (!aw_done && cyc >= lead)  awvalid = 1'b1;
      if (!w_done  && cyc >= -lead) wvalid = 1'b1;
      if (w_done && !aw_done) chk("wready_low_while_waiting_aw", wready, 1'b0);
      if (aw_done && !w_done) chk("awready_low_while_waiting_w", awready, 1'b0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("write_handshake_in_time", {aw_done, w_done}, 2'b11);
    $display("[TB] WR addr=%h data=%h strb=%b lead=%0d hold=%0d bresp=%b", addr, data, strb, lead, b_hold, bresp);
    chk("bvalid_on_write_edge", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("wr_pulse_first_cycle", reg_wr_pulse, exp_pulse);
    chk("reg_out_after_write", reg_out, mdl_flat());
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_held", bvalid, 1'b1);
      chk("bresp_held", bresp, exp_resp);
      chk("ready_low_in_resp", {awready, wready}, 2'b00);
      chk("wr_pulse_one_cycle", reg_wr_pulse, '0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_cleared", bvalid, 1'b0);
    chk("wr_pulse_cleared", reg_wr_pulse, '0);
    chk("write_idle_readies", {awready, wready}, 2'b11);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_hold,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit done = 0, hs;
    int cyc = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    while (!done && cyc < 20) begin
      hs = arvalid && arready;
      @(posedge clk); #1; cyc++;
      if (hs) begin done = 1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    chk("read_handshake_in_time", done, 1'b1);
    $display("[TB] RD addr=%h rdata=%h rresp=%b hold=%0d", addr, rdata, rresp, r_hold);
    chk("rvalid_latency", rvalid, 1'b1);
    chk("rdata", rdata, exp_data);
    chk("rresp", rresp, exp_resp);
    chk("arready_low_in_resp", arready, 1'b0);
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      chk("rvalid_held", rvalid, 1'b1);
      chk("rdata_held", rdata, exp_data);
      chk("rresp_held", rresp, exp_resp);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_cleared", rvalid, 1'b0);
    chk("read_idle_ready", arready, 1'b1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    int          hold;
    logic [31:0] exp_rdata;
    bit          oor;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [1:0]    e_resp;
    logic [NR-1:0] e_pulse;
    logic [31:0]   e_data;
    logic [31:0]   old;
    int            idx;

    tbl[0]  = '{1, 4'h0, 32'h00000001, 4'hF,  0, 0, 32'h0,        0};
    tbl[1]  = '{1, 4'h4, 32'h00000002, 4'hF, -2, 5, 32'h0,        0};
    tbl[2]  = '{1, 4'h8, 32'h00000003, 4'hF,  0, 0, 32'h0,        0};
    tbl[3]  = '{1, 4'hC, 32'h00000004, 4'hF,  0, 1, 32'h0,        1};
    tbl[4]  = '{0, 4'h0, 32'h0,        4'h0,  0, 0, 32'h00000001, 0};
    tbl[5]  = '{0, 4'h4, 32'h0,        4'h0,  0, 2, 32'h00000002, 0};
    tbl[6]  = '{0, 4'h8, 32'h0,        4'h0,  0, 0, 32'h00000003, 0};
    tbl[7]  = '{0, 4'hC, 32'h0,        4'h0,  0, 0, 32'h00000000, 1};
    tbl[8]  = '{1, 4'h0, 32'hAABBCCDD, 4'h3,  0, 0, 32'h0,        0};
    tbl[9]  = '{0, 4'h0, 32'h0,        4'h0,  0, 0, 32'h0000CCDD, 0};
    tbl[10] = '{1, 4'h8, 32'h00000055, 4'hF,  3, 0, 32'h0,        0};
    tbl[11] = '{0, 4'h8, 32'h0,        4'h0,  0, 0, 32'h00000055, 0};
    tbl[12] = '{1, 4'h5, 32'h12345678, 4'hC,  1, 0, 32'h0,        0};
    tbl[13] = '{0, 4'h7, 32'h0,        4'h0,  0, 0, 32'h12340002, 0};
    tbl[14] = '{1, 4'h4, 32'hFFFFFFFF, 4'h0,  0, 0, 32'h0,        0};
    tbl[15] = '{0, 4'h6, 32'h0,        4'h0,  0, 0, 32'h12340002, 0};
    tbl[16] = '{1, 4'hC, 32'h0000DEAD, 4'hF, -1, 0, 32'h0,        1};
    tbl[17] = '{0, 4'hE, 32'h0,        4'h0,  0, 1, 32'h00000000, 1};

    rst = 1'b1;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    chk("ready_low_before_first_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    chk("ready_after_release", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].is_wr) begin
        idx = int'(tbl[i].addr) / 4;
        e_resp  = tbl[i].oor ? OOR_RESP : 2'b00;
        e_pulse = '0;
        if (!tbl[i].oor) e_pulse[idx] = 1'b1;
        mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb, old[1:0], old[NR+1:2]);
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, tbl[i].hold, e_resp, e_pulse);
      end else begin
        axi_read(tbl[i].addr, tbl[i].hold, tbl[i].exp_rdata, tbl[i].oor ? OOR_RESP : 2'b00);
      end
    end

    // Read and write to the same register on one edge: the read sees the old value.
    old = mdl[1];
    awaddr = 4'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 4'h4;
    chk("idle_readies_before_rw", {awready, wready, arready}, 3'b111);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mdl[1] = 32'hCAFEF00D;
    $display("[TB] RW addr=4 rdata=%h bresp=%b", rdata, bresp);
    chk("rw_same_edge_rdata", rdata, old);
    chk("rw_same_edge_valids", {rvalid, bvalid}, 2'b11);
    chk("rw_same_edge_pulse", reg_wr_pulse, 3'b010);
    chk("rw_same_edge_regs", reg_out, mdl_flat());
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    chk("rw_handshakes_done", {rvalid, bvalid}, 2'b00);

    // Reset while holding an address: the pending write must be forgotten.
    awaddr = 4'h4; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("have_addr_readies", {awready, wready}, 2'b01);
    #2 rst = 1'b1;
    #1;
    $display("[TB] RESET asserted mid-write");
    check_reset_outputs("mid_reset");
    for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_mid_reset", {awready, wready, arready}, 3'b111);
    wdata = 32'h0000BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    $display("[TB] W alone after reset bvalid=%b", bvalid);
    chk("w_alone_no_bvalid", bvalid, 1'b0);
    chk("w_alone_no_pulse", reg_wr_pulse, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("w_alone_still_no_bvalid", bvalid, 1'b0);
    chk("w_alone_regs_untouched", reg_out, mdl_flat());
    awaddr = 4'h8; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    mdl[2] = 32'h0000BEEF;
    chk("late_aw_bvalid", bvalid, 1'b1);
    chk("late_aw_pulse", reg_wr_pulse, 3'b100);
    chk("late_aw_regs", reg_out, mdl_flat());
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  a = 4'($urandom_range(0, 15));
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom_range(0, 15));
      int          hold = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        mdl_write(a, d, s, e_resp, e_pulse);
        axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, hold, e_resp, e_pulse);
      end else begin
        mdl_read(a, e_data, e_resp);
        axi_read(a, hold, e_data, e_resp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
